// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } if_state_e;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_stage_skid_buf.sv
// One-entry pc+instruction buffer that parks a response while ID is stalled.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [31:0]        pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               valid,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] instr
);

  logic               valid_q, valid_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = pc_in;
      instr_d = instr_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: sequential fetch, redirect handling and IF/ID register.
// Define IF_STAGE_STALL_CNT_EN to add the stall_cnt output (cycles stalled with a live instruction).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  if_stage_if.master         imem,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               id_stall,
`ifdef IF_STAGE_STALL_CNT_EN
  output logic [31:0]        stall_cnt,
`endif
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  if_state_e          state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               redir_pend_q, redir_pend_d;
  logic [31:0]        redir_pc_q, redir_pc_d;
  logic               if_valid_q, if_valid_d;
  logic [31:0]        if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;

  logic               skid_load, skid_clear, skid_valid;
  logic [31:0]        skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               id_free;

  assign id_free        = !if_valid_q || !id_stall;
  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    if_valid_d   = if_valid_q && id_stall;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          skid_clear = 1'b1;
          if (imem.imem_ready) begin
            pc_d         = align_pc(redirect_pc);
            redir_pend_d = 1'b0;
          end else begin
            // Keep the outstanding request intact; its response is dropped later.
            redir_pend_d = 1'b1;
            redir_pc_d   = align_pc(redirect_pc);
          end
        end else if (imem.imem_ready) begin
          if (redir_pend_q) begin
            pc_d         = redir_pc_q;
            redir_pend_d = 1'b0;
          end else if (id_free) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem.imem_rdata;
            pc_d       = pc_q + PC_INC;
          end else begin
            skid_load = 1'b1;
            pc_d      = pc_q + PC_INC;
            state_d   = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          skid_clear = 1'b1;
          pc_d       = align_pc(redirect_pc);
          state_d    = S_FETCH;
        end else if (!id_stall) begin
          if_valid_d = skid_valid;
          if_pc_d    = skid_pc;
          if_instr_d = skid_instr;
          skid_clear = 1'b1;
          state_d    = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
    end
  end

  if_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .clear    (skid_clear),
    .pc_in    (pc_q),
    .instr_in (imem.imem_rdata),
    .valid    (skid_valid),
    .pc       (skid_pc),
    .instr    (skid_instr)
  );

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

`ifdef IF_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (if_valid_q && id_stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
